memory_unit: RTL and testbench

//   Single-port synchronous word memory directly downstream of the CPU memory

---
 rtl/memory_unit.sv | 135 +++++++++++++
 tb/tb_memory_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// -----------------------------------------------------------------------------
// memory_unit
//   Single-port synchronous word memory behind the CPU memory interface.
//   Serves instruction fetch, LD and STR through mem_en/read_write/address.
//   A clear sequencer, started by clr_mem, writes zero to every word, one word
//   per cycle, and holds busy high for the whole sweep (exactly DEPTH cycles).
//
// Ports
//   clk_in      in   1       single clock, all state changes on posedge
//   reset       in   1       asynchronous, active-low reset
//   mem_en      in   1       access request, sampled at posedge
//   read_write  in   1       0 = read, 1 = write
//   address     in   ADDR_W  word address
//   wr_data     in   DATA_W  write data
//   clr_mem     in   1       request a full-array clear, sampled at posedge
//   rd_data     out  DATA_W  registered read data
//   rd_valid    out  1       one-cycle pulse: rd_data updated this cycle
//   busy        out  1       high while the clear sweep is running
//   fsm_state   out  1       current sequencer state (0 = IDLE, 1 = CLEAR)
//
// Handshake: an access is accepted at any posedge where mem_en is high, the
// sequencer is IDLE and clr_mem is low; there is no back-pressure, so a
// request presented while busy (or together with clr_mem) is simply dropped.
// A read returns its data with rd_valid high after that same posedge.
//
// The array itself is never reset; reset only aborts the sweep and clears the
// output registers. Every output comes straight from a register.
// -----------------------------------------------------------------------------
module memory_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_mem,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [0:0]        fsm_state
);

    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DEPTH_M1 = DEPTH - 1;
    localparam logic [ADDR_W:0]  DEPTH_L = DEPTH[ADDR_W:0];
    localparam logic [IDX_W-1:0] LAST    = DEPTH_M1[IDX_W-1:0];

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [0:0]        state;
    logic [IDX_W-1:0]  clr_ptr;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Compare with one extra bit so DEPTH == 2**ADDR_W is representable.
    assign in_range  = ({1'b0, address} < DEPTH_L);
    assign idx       = address[IDX_W-1:0];
    assign fsm_state = state;

    // Single write port shared by the CPU and the clear sweep. Writes are
    // suppressed while reset is asserted so an aborted sweep stops at once.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = wr_data;
        if (reset) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = '0;
            end else if (!clr_mem && mem_en && read_write && in_range) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_mem) begin
                        // Clear wins over any access presented this cycle.
                        state    <= CLEAR;
                        clr_ptr  <= '0;
                        busy     <= 1'b1;
                        rd_valid <= 1'b0;
                    end else if (mem_en && !read_write) begin
                        rd_data  <= in_range ? mem[idx] : '0;
                        rd_valid <= 1'b1;
                    end else begin
                        rd_valid <= 1'b0;
                    end
                end
                CLEAR: begin
                    rd_valid <= 1'b0;
                    if (clr_ptr == LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + IDX_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_unit
//   Bench for memory_unit: a fixed vector table, a randomized phase checked
//   against an array model of the memory, and hand-written sequences for the
//   clear sweep, clear/access collisions, reset during a sweep and the
//   out-of-range behaviour of a DEPTH = 1024 instance.
// -----------------------------------------------------------------------------
module tb_memory_unit;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        mem_en = 1'b0;
    logic        read_write = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] wr_data = '0;
    logic        clr_mem = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [0:0]  fsm_state;

    // Second instance with a shallow array for the address-range checks.
    logic        s_mem_en = 1'b0;
    logic        s_rw     = 1'b0;
    logic [11:0] s_addr   = '0;
    logic [31:0] s_wdata  = '0;
    logic        s_clr    = 1'b0;
    logic [31:0] s_rd_data;
    logic        s_rd_valid;
    logic        s_busy;
    logic [0:0]  s_fsm;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] model_mem [0:4095];
    logic [31:0] last_rd;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        is_write;
        logic [11:0] addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    memory_unit u_dut (
        .clk_in(clk_in), .reset(reset), .mem_en(mem_en), .read_write(read_write),
        .address(address), .wr_data(wr_data), .clr_mem(clr_mem),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .fsm_state(fsm_state)
    );

    memory_unit #(.ADDR_W(12), .DATA_W(32), .DEPTH(1024)) u_small (
        .clk_in(clk_in), .reset(reset), .mem_en(s_mem_en), .read_write(s_rw),
        .address(s_addr), .wr_data(s_wdata), .clr_mem(s_clr),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .busy(s_busy), .fsm_state(s_fsm)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        mem_en = 1'b1; read_write = 1'b1; address = a; wr_data = d;
        tick();
        mem_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_read(input logic [11:0] a);
        mem_en = 1'b1; read_write = 1'b0; address = a;
        tick();
        mem_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        do_read(a);
        check({name, " valid"}, {31'b0, rd_valid}, 32'd1);
        check({name, " data"}, rd_data, exp);
    endtask

    task automatic s_write(input logic [11:0] a, input logic [31:0] d);
        s_mem_en = 1'b1; s_rw = 1'b1; s_addr = a; s_wdata = d;
        tick();
        s_mem_en = 1'b0;
    endtask

    task automatic s_read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        s_mem_en = 1'b1; s_rw = 1'b0; s_addr = a;
        tick();
        s_mem_en = 1'b0;
        check({name, " valid"}, {31'b0, s_rd_valid}, 32'd1);
        check({name, " data"}, s_rd_data, exp);
    endtask

    // Counts posedges until busy drops, bounded so a stuck sweep still ends.
    task automatic wait_sweep(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            tick();
            cyc++;
        end
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        vec_t vecs [12];
        int   cyc;

        vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 12'h010, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 12'h000, 32'h00000001};
        vecs[3]  = '{1'b1, 12'h000, 32'h00000002};
        vecs[4]  = '{1'b0, 12'h000, 32'h00000002};
        vecs[5]  = '{1'b1, 12'hFFF, 32'h00000007};
        vecs[6]  = '{1'b1, 12'h000, 32'h00000005};
        vecs[7]  = '{1'b0, 12'hFFF, 32'h00000007};
        vecs[8]  = '{1'b0, 12'h000, 32'h00000005};
        vecs[9]  = '{1'b1, 12'h123, 32'hCAFEF00D};
        vecs[10] = '{1'b0, 12'h123, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 12'h010, 32'hDEADBEEF};

        // Reset values while reset is held low.
        repeat (3) tick();
        check("rst rd_data", rd_data, 32'h0);
        check("rst rd_valid", {31'b0, rd_valid}, 32'h0);
        check("rst busy", {31'b0, busy}, 32'h0);
        check("rst state", {31'b0, fsm_state}, 32'h0);
        reset = 1'b1;
        tick();

        // Table-driven basic accesses.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write) begin
                do_write(vecs[i].addr, vecs[i].data);
                check($sformatf("vec%0d wr valid", i), {31'b0, rd_valid}, 32'h0);
            end else begin
                read_check($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].data);
            end
        end
        tick();
        check("idle valid", {31'b0, rd_valid}, 32'h0);
        check("idle hold", rd_data, 32'hDEADBEEF);

        // Full clear with dropped accesses during the sweep.
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        check("clr busy rise", {31'b0, busy}, 32'h1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            if (cyc == 5) begin
                mem_en = 1'b1; read_write = 1'b1; address = 12'h800; wr_data = 32'h9;
            end else if (cyc == 100) begin
                mem_en = 1'b1; read_write = 1'b1; address = 12'h005; wr_data = 32'h9;
            end else if (cyc == 200) begin
                mem_en = 1'b1; read_write = 1'b0; address = 12'h010;
            end else begin
                mem_en = 1'b0;
            end
            tick();
            cyc++;
            if (cyc == 201) begin
                check("sweep rd valid", {31'b0, rd_valid}, 32'h0);
                check("sweep rd hold", rd_data, 32'hDEADBEEF);
            end
        end
        mem_en = 1'b0;
        check("sweep length", cyc, 32'd4096);
        check("sweep state", {31'b0, fsm_state}, 32'h0);
        read_check("clr 000", 12'h000, 32'h0);
        read_check("clr 800", 12'h800, 32'h0);
        read_check("clr FFF", 12'hFFF, 32'h0);
        read_check("clr 005", 12'h005, 32'h0);
        read_check("clr 010", 12'h010, 32'h0);

        // Randomized traffic against the array model (memory is all zero now).
        for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
        last_rd = 32'h0;
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [11:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 2);
            a  = ($urandom_range(0, 7) == 0) ? 12'(4095 - $urandom_range(0, 3))
                                             : 12'($urandom_range(0, 15));
            d  = $urandom;
            if (op == 1) begin
                do_write(a, d);
                check("rnd wr valid", {31'b0, rd_valid}, 32'h0);
                check("rnd wr hold", rd_data, last_rd);
            end else if (op == 2) begin
                exp_q.push_back(model_mem[a]);
                do_read(a);
                last_rd = exp_q.pop_front();
                check("rnd rd valid", {31'b0, rd_valid}, 32'h1);
                check("rnd rd data", rd_data, last_rd);
            end else begin
                tick();
                check("rnd idle valid", {31'b0, rd_valid}, 32'h0);
                check("rnd idle hold", rd_data, last_rd);
            end
        end

        // Clear and a write in the same cycle: write dropped.
        do_write(12'h004, 32'h11);
        clr_mem = 1'b1; mem_en = 1'b1; read_write = 1'b1; address = 12'h004; wr_data = 32'hA5;
        tick();
        clr_mem = 1'b0; mem_en = 1'b0;
        check("clr+wr busy", {31'b0, busy}, 32'h1);
        wait_sweep(cyc);
        check("clr+wr sweep len", cyc, 32'd4096);
        read_check("clr+wr 004", 12'h004, 32'h0);

        // Clear and a read in the same cycle, clr_mem held during the sweep.
        do_write(12'h010, 32'h33);
        read_check("pre 010", 12'h010, 32'h33);
        clr_mem = 1'b1; mem_en = 1'b1; read_write = 1'b0; address = 12'h010;
        tick();
        mem_en = 1'b0;
        check("clr+rd valid", {31'b0, rd_valid}, 32'h0);
        check("clr+rd hold", rd_data, 32'h33);
        cyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            clr_mem = (cyc < 50);
            tick();
            cyc++;
        end
        clr_mem = 1'b0;
        check("held clr sweep len", cyc, 32'd4096);

        // Reset in the middle of a sweep.
        do_write(12'h000, 32'h77);
        do_write(12'h100, 32'h3);
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        repeat (10) tick();
        #2;
        reset = 1'b0;
        #1;
        check("abort busy", {31'b0, busy}, 32'h0);
        check("abort state", {31'b0, fsm_state}, 32'h0);
        check("abort rd_data", rd_data, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        read_check("abort 000", 12'h000, 32'h0);
        read_check("abort 100", 12'h100, 32'h3);

        // Shallow instance: out-of-range reads return 0, writes are dropped.
        s_write(12'h000, 32'h55);
        s_read_check("small 000", 12'h000, 32'h55);
        s_read_check("small 400", 12'h400, 32'h0);
        s_write(12'h400, 32'h8);
        s_read_check("small alias", 12'h000, 32'h55);
        s_read_check("small 3FF hi", 12'hFFF, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
